// File: rtl/latch_shift_reader.sv
// Pi-side serial reader for the TI/Pi byte latches: snapshots one selected byte on a
// load strobe and shifts it out MSB (bit 0) first, one bit per Pi shift-clock rise.
module latch_shift_reader #(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:NBITS-1] td_in,
  input  logic [0:NBITS-1] tc_in,
  input  logic [0:NBITS-1] rd_in,
  input  logic [0:NBITS-1] rc_in,
  input  logic [1:0]       r_reg,
  input  logic             r_le,
  input  logic             r_clk,
  output logic             r_dout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = ($clog2(NBITS) > 0) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Pi pin synchronizers plus one edge-detect flop per strobe
  logic [SYNC_STAGES-1:0] le_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [1:0]             sel_sync_q [SYNC_STAGES];
  logic                   le_prev_q;
  logic                   clk_prev_q;

  logic       le_s;
  logic       clk_s;
  logic [1:0] sel_s;
  logic       le_rise;
  logic       clk_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      le_sync_q  <= '0;
      clk_sync_q <= '0;
      le_prev_q  <= 1'b0;
      clk_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sel_sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old
      // value, so the chain really is SYNC_STAGES flops deep regardless of order.
      le_sync_q     <= {le_sync_q[SYNC_STAGES-2:0], r_le};
      clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], r_clk};
      le_prev_q     <= le_s;
      clk_prev_q    <= clk_s;
      sel_sync_q[0] <= r_reg;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sel_sync_q[i] <= sel_sync_q[i-1];
      end
    end
  end

  assign le_s     = le_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign sel_s    = sel_sync_q[SYNC_STAGES-1];
  assign le_rise  = le_s & ~le_prev_q;
  assign clk_rise = clk_s & ~clk_prev_q;

  // Byte selected by the synchronized register select
  logic [0:NBITS-1] load_byte;

  always_comb begin
    load_byte = td_in;
    case (sel_s)
      2'd0: load_byte = td_in;
      2'd1: load_byte = tc_in;
      2'd2: load_byte = rd_in;
      2'd3: load_byte = rc_in;
      default: load_byte = td_in;
    endcase
  end

  state_t           state_q, state_d;
  logic [0:NBITS-1] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (le_rise) begin
          sreg_d  = load_byte;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A load in the same cycle as a shift restarts the frame; the shift is dropped
        if (le_rise) begin
          sreg_d = load_byte;
          cnt_d  = '0;
        end else if (clk_rise) begin
          if (cnt_q == LAST_BIT) begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sreg_d = {sreg_q[1:NBITS-1], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they move with the frame state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      r_dout  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      r_dout  <= sreg_d[0];
      busy    <= (state_d == SHIFT);
      done    <= done_d;
    end
  end

endmodule
